// File: rtl/loadable_updown_modn_counter.sv
// Loadable up/down modulo-MODULUS counter with wrap/saturate select,
// terminal-count flag, wrap pulse + saturating wrap counter, and bad-load flag.
module loadable_updown_modn_counter #(
  parameter int WIDTH      = 4,
  parameter int MODULUS    = 12,
  parameter int WRAP_CNT_W = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  load,
  input  logic                  mode,
  input  logic                  sat_mode,
  input  logic [WIDTH-1:0]      data_in,
  output logic [WIDTH-1:0]      data_out,
  output logic                  tc,
  output logic                  wrap_pulse,
  output logic [WRAP_CNT_W-1:0] wrap_count,
  output logic                  load_err
);

  localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULUS - 1);

  // Widened compare so MODULUS == 2**WIDTH can never flag an error.
  logic load_oor;
  assign load_oor = {1'b0, data_in} >= (WIDTH+1)'(MODULUS);

  assign tc = mode ? (data_out == TOP) : (data_out == '0);

  always_ff @(posedge clock) begin
    if (!reset) begin
      data_out   <= '0;
      wrap_pulse <= 1'b0;
      wrap_count <= '0;
      load_err   <= 1'b0;
    end else if (load) begin
      data_out   <= load_oor ? TOP : data_in;
      load_err   <= load_oor;
      wrap_pulse <= 1'b0;
    end else if (enable) begin
      load_err <= 1'b0;
      if (tc) begin
        // At terminal: saturate holds, wrap jumps to the opposite end.
        if (sat_mode) begin
          wrap_pulse <= 1'b0;
        end else begin
          data_out   <= mode ? '0 : TOP;
          wrap_pulse <= 1'b1;
          if (wrap_count != '1)
            wrap_count <= wrap_count + WRAP_CNT_W'(1);
        end
      end else begin
        data_out   <= mode ? data_out + WIDTH'(1) : data_out - WIDTH'(1);
        wrap_pulse <= 1'b0;
      end
    end else begin
      wrap_pulse <= 1'b0;
      load_err   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_loadable_updown_modn_counter.sv
// Scoreboard bench: four parameterisations driven in lockstep, expected
// responses queued at stimulus time and checked by an independent monitor.
module tb_loadable_updown_modn_counter;

  localparam int N = 4;
  localparam int MODS [N] = '{12, 12, 16, 5};
  localparam int WMAX [N] = '{255, 3, 255, 255};
  localparam int WID  [N] = '{4, 4, 4, 3};

  logic       clk = 1'b0;
  logic       rst_n, en, ld, md, sat;
  logic [3:0] din;

  always #5 clk = ~clk;

  logic [3:0] d0, d1, d2;
  logic [2:0] d3;
  logic [7:0] w0, w2, w3;
  logic [1:0] w1;
  logic [N-1:0] tcv, wpv, lev;
  int dout [N];
  int wcnt [N];

  loadable_updown_modn_counter #(.WIDTH(4), .MODULUS(12), .WRAP_CNT_W(8)) u0 (
    .clock(clk), .reset(rst_n), .enable(en), .load(ld), .mode(md), .sat_mode(sat),
    .data_in(din), .data_out(d0), .tc(tcv[0]), .wrap_pulse(wpv[0]),
    .wrap_count(w0), .load_err(lev[0]));
  loadable_updown_modn_counter #(.WIDTH(4), .MODULUS(12), .WRAP_CNT_W(2)) u1 (
    .clock(clk), .reset(rst_n), .enable(en), .load(ld), .mode(md), .sat_mode(sat),
    .data_in(din), .data_out(d1), .tc(tcv[1]), .wrap_pulse(wpv[1]),
    .wrap_count(w1), .load_err(lev[1]));
  loadable_updown_modn_counter #(.WIDTH(4), .MODULUS(16), .WRAP_CNT_W(8)) u2 (
    .clock(clk), .reset(rst_n), .enable(en), .load(ld), .mode(md), .sat_mode(sat),
    .data_in(din), .data_out(d2), .tc(tcv[2]), .wrap_pulse(wpv[2]),
    .wrap_count(w2), .load_err(lev[2]));
  loadable_updown_modn_counter #(.WIDTH(3), .MODULUS(5), .WRAP_CNT_W(8)) u3 (
    .clock(clk), .reset(rst_n), .enable(en), .load(ld), .mode(md), .sat_mode(sat),
    .data_in(din[2:0]), .data_out(d3), .tc(tcv[3]), .wrap_pulse(wpv[3]),
    .wrap_count(w3), .load_err(lev[3]));

  always_comb begin
    dout[0] = int'(d0); dout[1] = int'(d1); dout[2] = int'(d2); dout[3] = int'(d3);
    wcnt[0] = int'(w0); wcnt[1] = int'(w1); wcnt[2] = int'(w2); wcnt[3] = int'(w3);
  end

  // Reference model: plain integer counter arithmetic per instance.
  int m_d [N];
  int m_wp [N];
  int m_wc [N];
  int m_le [N];

  typedef struct { int k; int d; int wp; int wc; int le; int md; } exp_t;
  exp_t q[$];

  int errors = 0;
  int checks = 0;

  task automatic model_step(input int k);
    int m, v, nd;
    m = MODS[k];
    if (!rst_n) begin
      m_d[k] = 0; m_wp[k] = 0; m_wc[k] = 0; m_le[k] = 0;
    end else if (ld) begin
      v = int'(din) % (1 << WID[k]);
      if (v < m) begin m_d[k] = v; m_le[k] = 0; end
      else begin m_d[k] = m - 1; m_le[k] = 1; end
      m_wp[k] = 0;
    end else if (en) begin
      m_le[k] = 0;
      nd = md ? m_d[k] + 1 : m_d[k] - 1;
      if (nd >= 0 && nd < m) begin
        m_d[k] = nd; m_wp[k] = 0;
      end else if (sat) begin
        m_wp[k] = 0;
      end else begin
        m_d[k] = md ? 0 : m - 1;
        m_wp[k] = 1;
        if (m_wc[k] < WMAX[k]) m_wc[k] = m_wc[k] + 1;
      end
    end else begin
      m_wp[k] = 0; m_le[k] = 0;
    end
  endtask

  task automatic cyc(input bit r, input bit l, input bit e, input bit m,
                     input bit s, input logic [3:0] di);
    exp_t x;
    rst_n = r; ld = l; en = e; md = m; sat = s; din = di;
    for (int k = 0; k < N; k++) begin
      model_step(k);
      x.k = k; x.d = m_d[k]; x.wp = m_wp[k]; x.wc = m_wc[k]; x.le = m_le[k];
      x.md = int'(m);
      q.push_back(x);
    end
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int k, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s inst%0d: got %0d expected %0d at %0t", name, k, act, req, $time);
    end
  endtask

  // Monitor: outputs are presented every cycle; drain all pending entries.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        e = q.pop_front();
        chk("data_out",   e.k, dout[e.k],        e.d);
        chk("wrap_pulse", e.k, int'(wpv[e.k]),   e.wp);
        chk("wrap_count", e.k, wcnt[e.k],        e.wc);
        chk("load_err",   e.k, int'(lev[e.k]),   e.le);
        chk("tc",         e.k, int'(tcv[e.k]),
            (e.md != 0) ? int'(e.d == MODS[e.k] - 1) : int'(e.d == 0));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; ld = 1'b0; en = 1'b0; md = 1'b1; sat = 1'b0; din = '0;
    @(negedge clk);
    #1;
    // Reset, then up-count wrap through 11 -> 0.
    cyc(0, 0, 0, 1, 0, 4'd0);
    repeat (13) cyc(1, 0, 1, 1, 0, 4'd0);
    // Load 5, saturating down-count holds at 0.
    cyc(1, 1, 0, 1, 1, 4'd5);
    repeat (8) cyc(1, 0, 1, 0, 1, 4'd0);
    // Out-of-range load, then legal load, then hold.
    cyc(1, 1, 0, 0, 0, 4'd14);
    cyc(1, 1, 0, 0, 0, 4'd3);
    cyc(1, 0, 0, 0, 0, 4'd0);
    // Load wins over counting at terminal; reset wins over load.
    cyc(1, 1, 0, 1, 0, 4'd10);
    cyc(1, 0, 1, 1, 0, 4'd0);
    cyc(1, 1, 1, 1, 0, 4'd7);
    cyc(0, 1, 1, 1, 0, 4'd9);
    // Five full up-wrap periods to saturate the narrow wrap counter.
    repeat (62) cyc(1, 0, 1, 1, 0, 4'd0);
    // Down-wrap from 0 in every parameterisation, then hold.
    cyc(0, 0, 0, 0, 0, 4'd0);
    cyc(1, 0, 1, 0, 0, 4'd0);
    cyc(1, 0, 0, 0, 0, 4'd0);
    // Random traffic.
    repeat (600) begin
      cyc($urandom_range(0, 49) != 0, $urandom_range(0, 7) == 0,
          $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    end
    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/loadable_updown_modn_counter.md
Name: loadable_updown_modn_counter

Overview:
- Parametrised successor to the mod-12 loadable up/down counter: modulus, width and wrap-event counter width are generic.
- Adds count enable, run-time wrap/saturate selection, terminal-count flag, registered wrap pulse with event counter, and out-of-range load detection.
- Drops into the counter testbench and environment (interface, driver, monitor, scoreboard) as the DUV, with the interface widened accordingly.

Parameters:
- WIDTH, 4, bit width of data_in/data_out; MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH.
- MODULUS, 12, count sequence is 0..MODULUS-1.
- WRAP_CNT_W, 8, width of wrap_count.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous reset, active-low.
- enable  input  1  count enable; load is honoured regardless of enable.
- load  input  1  load data_in on next clock edge.
- mode  input  1  1 = count up, 0 = count down.
- sat_mode  input  1  1 = saturate at end of range, 0 = wrap modulo MODULUS.
- data_in  input  WIDTH  load value.
- data_out  output  WIDTH  registered count.
- tc  output  1  combinational terminal count: (mode=1 && data_out==MODULUS-1) || (mode=0 && data_out==0).
- wrap_pulse  output  1  registered; high for exactly one cycle after a wrap occurred.
- wrap_count  output  WRAP_CNT_W  registered number of wraps since reset; saturates at all-ones.
- load_err  output  1  registered; high for one cycle after a load with data_in >= MODULUS.

Behaviour:
- Reset (sampled at rising clock edge, reset==0):
  - data_out=0, wrap_pulse=0, wrap_count=0, load_err=0.
  - Overrides load and enable in the same cycle, including mid-count.
- Priority per edge: reset > load > enable count > hold.
- Load:
  - data_in < MODULUS: data_out<=data_in, load_err<=0.
  - data_in >= MODULUS: data_out<=MODULUS-1, load_err<=1.
  - A load never asserts wrap_pulse or changes wrap_count.
- Count (enable=1, load=0):
  - mode=1: data_out<=data_out+1; at MODULUS-1, wrap mode gives 0 and saturate mode holds MODULUS-1.
  - mode=0: data_out<=data_out-1; at 0, wrap mode gives MODULUS-1 and saturate mode holds 0.
  - A wrap is a wrap-mode transition from a terminal value. It sets wrap_pulse<=1 and wrap_count<=wrap_count+1 unless wrap_count is all-ones, in which case it holds.
  - A saturate-mode hold at terminal is not a wrap: wrap_pulse<=0.
- Hold (enable=0, load=0): data_out unchanged; wrap_pulse<=0; load_err<=0.
- wrap_pulse and load_err are cleared on every edge on which their set condition is false; there are no sticky bits.
- Mode or sat_mode may change on any cycle and take effect on the next edge. tc follows mode combinationally within the same cycle.
- Latency: data_out is updated one edge after inputs are sampled. wrap_pulse, wrap_count and load_err update on the same edge as data_out.
- Arithmetic: next-state computed at WIDTH bits with explicit terminal compare. No reliance on natural 2**WIDTH overflow, except when MODULUS==2**WIDTH, where the result is identical either way.
- No X propagation after reset; all outputs are defined every cycle after the first reset edge.

Test Plan:
- Reset then enable=1, mode=1, sat_mode=0 for 13 clocks: data_out 0,1..11,0. tc=1 when data_out=11. wrap_pulse high for one cycle after 11->0. wrap_count=1.
- Load 5, then mode=0, sat_mode=1, enable=1 for 8 clocks: data_out 5,4,3,2,1,0,0,0. tc=1 at 0. wrap_pulse stays 0. wrap_count unchanged.
- load=1 with data_in=14 (MODULUS=12): data_out=11 and load_err=1 for exactly one cycle. A following load of 3 gives data_out=3 and load_err=0.
- Counting up at data_out=11 with load=1, data_in=7 on the same edge: data_out=7, no wrap_pulse. Next: reset=0 asserted mid-count with load=1: all outputs 0 on that edge.
- WRAP_CNT_W=2, continuous up-wrap for 5 full periods: wrap_count 1,2,3,3,3. wrap_pulse still pulses on each wrap.
- Parameter sweep WIDTH=4, MODULUS=16 and WIDTH=3, MODULUS=5, down-counting from 0 in wrap mode: data_out goes to 15 and 4 respectively, with wrap_pulse=1 on the following cycle.
